// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
package prod_accumulator_pkg;

  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned PROD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accumulator_acc_adder.sv
// Ripple-carry adder for the accumulator, assembled from full-adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module acc_adder
  import prod_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);
  logic [ACC_W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < ACC_W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[ACC_W];
endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a programmed-length burst of multiplier products and presents
// the sum on a held valid/ready output.
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  state_t             state, next_state;
  logic [LEN_W-1:0]   remaining;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;

  assign prod_ext = ACC_W'(in_prod);

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .a    (acc),
    .b    (prod_ext),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = (len != '0) ? ST_ACCUM : ST_DONE;
      ST_ACCUM: if (in_valid && remaining == LEN_W'(1)) next_state = ST_DONE;
      ST_DONE:  if (out_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= next_state;
      // acc/ovf are left untouched outside IDLE-start and ACCUM so the result holds after DONE
      if (state == ST_IDLE && start) begin
        remaining <= len;
        acc       <= '0;
        ovf       <= 1'b0;
      end else if (state == ST_ACCUM && in_valid) begin
        remaining <= remaining - LEN_W'(1);
        acc       <= add_sum;
        ovf       <= ovf | add_cout;
      end
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: a 12-bit and an 8-bit instance share stimulus
// and are compared every cycle against a burst-level reference model.
module tb_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_prod = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [11:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [7:0]  out_sum_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prod_accumulator #(.ACC_W(12), .LEN_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_ovf(out_ovf_a), .busy(busy_a)
  );

  prod_accumulator #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_ovf(out_ovf_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase 0=idle 1=collecting 2=result, true (unbounded) sum.
  int m_phase = 0;
  int m_sum   = 0;
  int m_left  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_sum = 0; m_left = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_sum = 0;
             m_left = int'(len);
             m_phase = (len != 0) ? 1 : 2;
           end
        1: if (in_valid) begin
             m_sum += int'(in_prod);
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("in_ready12",  int'(in_ready_a),  int'(m_phase == 1));
    check("out_valid12", int'(out_valid_a), int'(m_phase == 2));
    check("busy12",      int'(busy_a),      int'(m_phase != 0));
    check("sum12",       int'(out_sum_a),   m_sum % 4096);
    check("ovf12",       int'(out_ovf_a),   int'(m_sum >= 4096));
    check("in_ready8",   int'(in_ready_b),  int'(m_phase == 1));
    check("out_valid8",  int'(out_valid_b), int'(m_phase == 2));
    check("sum8",        int'(out_sum_b),   m_sum % 256);
    check("ovf8",        int'(out_ovf_b),   int'(m_sum >= 256));
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic do_start(input int l);
    start = 1'b1;
    len   = 4'(l);
    @(negedge clk);
    start = 1'b0;
    len   = 4'($urandom);
  endtask

  task automatic send(input int p, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_prod  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_prod  = 8'(p);
    @(negedge clk);
    in_valid = 1'b0;
    in_prod  = 8'($urandom);
  endtask

  task automatic wait_done(input int hold, input bit chk,
                           input int e12, input int o12, input int e8, input int o8);
    for (int i = 0; i < 40 && !out_valid_a; i++) @(negedge clk);
    check("done_reached", int'(out_valid_a), 1);
    if (chk) begin
      check("lit_sum12", int'(out_sum_a), e12);
      check("lit_ovf12", int'(out_ovf_a), o12);
      check("lit_sum8",  int'(out_sum_b), e8);
      check("lit_ovf8",  int'(out_ovf_b), o8);
    end
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int ref_sum, l, m, q;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back products, latency to out_valid after last accept.
    do_start(3);
    send(8'h0F, 0); send(8'hE1, 0); send(8'h10, 0);
    check("latency_valid", int'(out_valid_a), 1);
    wait_done(0, 1'b1, 12'h100, 0, 8'h00, 1);

    // Gapped input; in_ready must hold through the gaps.
    do_start(2);
    send(8'h33, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_in_gap", int'(in_ready_a), 1);
    @(negedge clk);
    send(8'h44, 0);
    wait_done(1, 1'b1, 12'h077, 0, 8'h77, 0);

    // Longest burst, wraps only the narrow instance.
    do_start(15);
    for (int i = 0; i < 15; i++) send(8'hE1, 0);
    wait_done(0, 1'b1, 12'hD2F, 0, 8'h2F, 1);

    // Zero-length burst with held result and ignored starts.
    do_start(0);
    check("len0_valid", int'(out_valid_a), 1);
    check("len0_sum",   int'(out_sum_a), 0);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = 4'd7;
      @(negedge clk);
      check("len0_hold_valid", int'(out_valid_a), 1);
      check("len0_hold_sum",   int'(out_sum_a), 0);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("start_in_done_ignored", int'(busy_a), 0);
    @(negedge clk);
    check("still_idle", int'(busy_a), 0);

    // Reset mid-burst.
    do_start(4);
    send(8'h80, 0); send(8'h91, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready",  int'(in_ready_a),  0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_out_sum",   int'(out_sum_a),   0);
    check("rst_out_ovf",   int'(out_ovf_b),   0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(1);
    send(8'h05, 0);
    wait_done(0, 1'b1, 12'h005, 0, 8'h05, 0);

    // Random multiplier-fed bursts.
    for (int b = 0; b < 25; b++) begin
      l = $urandom_range(1, 15);
      ref_sum = 0;
      do_start(l);
      for (int k = 0; k < l; k++) begin
        m = $urandom_range(0, 15);
        q = $urandom_range(0, 15);
        ref_sum += m * q;
        send(m * q, $urandom_range(0, 2));
      end
      wait_done($urandom_range(0, 3), 1'b1, ref_sum % 4096, int'(ref_sum >= 4096),
                ref_sum % 256, int'(ref_sum >= 256));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
